ps2_kb_rx_fifo: RTL
===================

Name: ps2_kb_rx_fifo

Overview:
- Next-generation PS/2 keyboard receiver. Runs entirely in the system clock domain; KB_Clk and KB_Data are oversampled, not used as clocks.
- Validates each 11-bit frame (start, 8 data, odd parity, stop) and decodes the E0 (extended) and F0 (release) prefixes into flags.
- Queues complete key events in a parametrised first-word-fall-through FIFO for the CPU/IO bus.
- Replaces single-byte, release-only reporting with press/release events, error reporting and buffering.

Parameters:
- FIFO_DEPTH, 8, number of queued key events; power of 2, ≥2.
- FILTER_LEN, 4, Clk cycles KB_Clk must stay stable before a level change is accepted.
- TIMEOUT_CYCLES, 100000, Clk cycles without an accepted KB_Clk falling edge, mid-frame, before the frame is aborted.

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  synchronous reset, active-low.
- KB_Clk  in  1  PS/2 clock from the device, asynchronous.
- KB_Data  in  1  PS/2 data from the device, asynchronous.
- Rd_En  in  1  pops the head event; ignored when Kb_Valid=0.
- Kb_Byte  out  8  head event scan code; 8'h00 when the FIFO is empty.
- Kb_Break  out  1  head event is a release (F0 seen).
- Kb_Ext  out  1  head event is extended (E0 seen).
- Kb_Valid  out  1  FIFO not empty.
- Fifo_Count  out  $clog2(FIFO_DEPTH)+1  number of queued events.
- Parity_Err  out  1  1-cycle pulse: frame dropped for bad parity.
- Frame_Err  out  1  1-cycle pulse: frame dropped for bad stop bit or timeout.
- Overflow  out  1  1-cycle pulse: event dropped because the FIFO is full.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low. While Rst_n=0 at a Clk edge:
  - FSM goes to IDLE; FIFO is emptied; pending E0/F0 flags are cleared.
  - Outputs: Kb_Byte=0, Kb_Break=0, Kb_Ext=0, Kb_Valid=0, Fifo_Count=0, all error pulses 0.
  - A frame in progress when reset asserts is discarded. No partial data survives reset.
- Input conditioning:
  - KB_Clk and KB_Data each pass through a 2-flop synchronizer.
  - Synchronized KB_Clk feeds a FILTER_LEN stable-count glitch filter.
  - A "fall" strobe fires for one cycle on the filtered 1→0 transition. KB_Data (synchronized) is sampled on that cycle.
- Frame FSM (advances only on fall strobes):
  - IDLE: data=0 → DATA with bit index 0. data=1 is a false start: stay in IDLE, no error.
  - DATA: shift data in LSB first. After the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: evaluate the frame, then return to IDLE:
    - stop bit=0 → Frame_Err.
    - else, ^{data,parity}≠1 → Parity_Err.
    - else the byte is delivered to the decoder.
  - Timeout: in any state other than IDLE, TIMEOUT_CYCLES cycles without a fall strobe → IDLE and Frame_Err. The counter reloads on every fall strobe.
- Decoder (runs in the cycle after a good STOP):
  - E0: set ext_pend; nothing is pushed.
  - F0: set brk_pend; nothing is pushed.
  - Any other byte (including E1): push {ext_pend, brk_pend, byte}, then clear both flags.
  - Any Parity_Err or Frame_Err also clears both flags.
- FIFO:
  - First-word-fall-through: outputs show the head entry.
  - Push latency: an event appears on Kb_Byte/Kb_Valid 2 Clk after the STOP fall strobe.
  - Rd_En with Kb_Valid=1 pops at the Clk edge; the next entry (or the empty values) appears the following cycle.
  - Push while full with no pop: event dropped, Overflow pulses, FIFO unchanged.
  - Push and pop in the same cycle: both take effect and Fifo_Count is unchanged. This also applies when full, so no overflow.
  - Rd_En while empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset mid-frame: drive 5 bits of a frame, pulse Rst_n low for 1 Clk, then send frame 0x1C → exactly one event: Kb_Byte=0x1C, Break=0, Ext=0, Count=1.
- Press/release: send 0x1C, F0, 1C → two events: {0,0,1C} then {0,1,1C}. Pop both → Kb_Valid=0, Kb_Byte=0x00.
- Extended: send E0, 75, E0, F0, 75 → events {1,0,75} and {1,1,75}.
- Errors: frame 0x1C with even parity → Parity_Err pulse, no push. Frame with stop=0 → Frame_Err. Stop clocking after 4 bits → Frame_Err after TIMEOUT_CYCLES. Then send F0 and a bad-parity frame → brk_pend cleared, so a following 0x1C is pushed with Break=0.
- Overflow: FIFO_DEPTH=4, send 5 codes without reading → Count=4, one Overflow pulse, first 4 codes read back in order.
- Full with simultaneous read: at Count=4, assert Rd_En on the cycle of a push → Count stays 4, no Overflow, and the new code is last in order.
- Glitch: 2-cycle low pulse on KB_Clk with FILTER_LEN=4 → no fall strobe, FSM state unchanged.

Source files
------------

// File: rtl/ps2_kb_rx_fifo.sv
// PS/2 keyboard receiver: oversampled clock/data, frame validation, E0/F0 prefix
// decoding and a first-word-fall-through queue of key events.
module ps2_kb_rx_fifo #(
   parameter int FIFO_DEPTH     = 8,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                          Clk,
   input  logic                          Rst_n,
   input  logic                          KB_Clk,
   input  logic                          KB_Data,
   input  logic                          Rd_En,
   output logic [7:0]                    Kb_Byte,
   output logic                          Kb_Break,
   output logic                          Kb_Ext,
   output logic                          Kb_Valid,
   output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count,
   output logic                          Parity_Err,
   output logic                          Frame_Err,
   output logic                          Overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int FLT_W = $clog2(FILTER_LEN + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } key_evt_t;

   // ------------------------------------------------------------------
   // Input synchronizers (idle PS/2 lines are high)
   // ------------------------------------------------------------------
   logic kbc_meta_q, kbc_sync_q;
   logic kbd_meta_q, kbd_sync_q;

   // NOTE: sequential state is always written with <= so every flop samples
   // the pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         kbc_meta_q <= 1'b1;
         kbc_sync_q <= 1'b1;
         kbd_meta_q <= 1'b1;
         kbd_sync_q <= 1'b1;
      end else begin
         kbc_meta_q <= KB_Clk;
         kbc_sync_q <= kbc_meta_q;
         kbd_meta_q <= KB_Data;
         kbd_sync_q <= kbd_meta_q;
      end
   end

   // ------------------------------------------------------------------
   // KB_Clk glitch filter and falling-edge strobe
   // ------------------------------------------------------------------
   logic             kbc_filt_q, kbc_filt_d;
   logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
   logic             fall;

   // NOTE: every signal driven here gets a default first, so no path through
   // the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      kbc_filt_d = kbc_filt_q;
      flt_cnt_d  = '0;
      fall       = 1'b0;
      if (kbc_sync_q != kbc_filt_q) begin
         if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
            kbc_filt_d = kbc_sync_q;
            fall       = kbc_filt_q;
         end else begin
            flt_cnt_d = flt_cnt_q + FLT_W'(1);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         kbc_filt_q <= 1'b1;
         flt_cnt_q  <= '0;
      end else begin
         kbc_filt_q <= kbc_filt_d;
         flt_cnt_q  <= flt_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   state_e          state_q, state_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            parity_q, parity_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            byte_ok_q, byte_ok_d;
   logic [7:0]      byte_q, byte_d;
   logic            parity_err_q, parity_err_d;
   logic            frame_err_q, frame_err_d;

   always_comb begin
      state_d      = state_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      parity_d     = parity_q;
      to_cnt_d     = to_cnt_q;
      byte_ok_d    = 1'b0;
      byte_d       = byte_q;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;

      if (fall || state_q == S_IDLE) begin
         to_cnt_d = '0;
      end else begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (fall && !kbd_sync_q) begin
               state_d   = S_DATA;
               bit_idx_d = 3'd0;
            end
         end
         S_DATA: begin
            if (fall) begin
               shift_d   = {kbd_sync_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_PARITY;
               end
            end
         end
         S_PARITY: begin
            if (fall) begin
               parity_d = kbd_sync_q;
               state_d  = S_STOP;
            end
         end
         S_STOP: begin
            if (fall) begin
               state_d = S_IDLE;
               if (!kbd_sync_q) begin
                  frame_err_d = 1'b1;
               end else if (^{shift_q, parity_q} != 1'b1) begin
                  parity_err_d = 1'b1;
               end else begin
                  byte_ok_d = 1'b1;
                  byte_d    = shift_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A device that stops clocking mid-frame must not wedge the receiver.
      if (state_q != S_IDLE && !fall && to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
         state_d     = S_IDLE;
         frame_err_d = 1'b1;
         to_cnt_d    = '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q      <= S_IDLE;
         bit_idx_q    <= 3'd0;
         shift_q      <= 8'h00;
         parity_q     <= 1'b0;
         to_cnt_q     <= '0;
         byte_ok_q    <= 1'b0;
         byte_q       <= 8'h00;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         parity_q     <= parity_d;
         to_cnt_q     <= to_cnt_d;
         byte_ok_q    <= byte_ok_d;
         byte_q       <= byte_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // ------------------------------------------------------------------
   // Prefix decoder
   // ------------------------------------------------------------------
   logic     ext_pend_q, ext_pend_d;
   logic     brk_pend_q, brk_pend_d;
   logic     push;
   key_evt_t push_evt;

   always_comb begin
      ext_pend_d = ext_pend_q;
      brk_pend_d = brk_pend_q;
      push       = 1'b0;
      push_evt   = '{ext: ext_pend_q, brk: brk_pend_q, code: byte_q};
      if (parity_err_q || frame_err_q) begin
         ext_pend_d = 1'b0;
         brk_pend_d = 1'b0;
      end else if (byte_ok_q) begin
         case (byte_q)
            8'hE0:   ext_pend_d = 1'b1;
            8'hF0:   brk_pend_d = 1'b1;
            default: begin
               push       = 1'b1;
               ext_pend_d = 1'b0;
               brk_pend_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         ext_pend_q <= 1'b0;
         brk_pend_q <= 1'b0;
      end else begin
         ext_pend_q <= ext_pend_d;
         brk_pend_q <= brk_pend_d;
      end
   end

   // ------------------------------------------------------------------
   // Event FIFO (first-word-fall-through)
   // ------------------------------------------------------------------
   key_evt_t         mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             pop, full, do_push;
   key_evt_t         head;

   assign pop     = Rd_En && (count_q != '0);
   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign do_push = push && (!full || pop);

   always_comb begin
      wr_ptr_d   = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d    = count_q;
      overflow_d = push && full && !pop;
      if (do_push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !do_push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // NOTE: storage is deliberately left out of reset; the count/pointers
   // define what is valid and the outputs are gated by Kb_Valid.
   always_ff @(posedge Clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_evt;
      end
   end

   assign head       = mem_q[rd_ptr_q];
   assign Kb_Valid   = (count_q != '0);
   assign Kb_Byte    = Kb_Valid ? head.code : 8'h00;
   assign Kb_Break   = Kb_Valid & head.brk;
   assign Kb_Ext     = Kb_Valid & head.ext;
   assign Fifo_Count = count_q;
   assign Parity_Err = parity_err_q;
   assign Frame_Err  = frame_err_q;
   assign Overflow   = overflow_q;

endmodule
